// File: rtl/updown_pkg.sv
// Shared types for the up/down counter slice.
// Latency: n/a (type and helper definitions only).
// Backpressure: n/a.
package updown_pkg;

  // Behaviour at the ends of the 0..limit range.
  typedef enum logic {
    WRAP     = 1'b0,
    SATURATE = 1'b1
  } counter_mode_e;

endpackage : updown_pkg

// File: rtl/sticky_flag.sv
// Sticky event flag: set by a one-cycle event, cleared by software.
// Latency: q rises/falls one clk after set/clr; async reset clears immediately.
// Backpressure: none; set wins over a coincident clr so no event is lost.
module sticky_flag (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clr,
  output logic q
);

  // Set has priority so an event landing on the clear cycle stays visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else if (set) begin
      q <= 1'b1;
    end else if (clr) begin
      q <= 1'b0;
    end
  end

endmodule : sticky_flag

// File: rtl/param_updown_counter.sv
// Up/down counter over 0..limit with wrap or saturate ends, load/clear and sticky flags.
// Latency: count and wrap_pulse update one clk after the controlling inputs; at_max/at_min are combinational.
// Backpressure: none; one step per enabled cycle, clear > load > enable > hold.
module param_updown_counter
  import updown_pkg::*;
#(
  parameter int          WIDTH     = 8,  // 2..32
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             up_down,
  input  counter_mode_e    mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             sticky_clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap_pulse,
  output logic             ovf_sticky,
  output logic             unf_sticky
);

  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_nxt;
  logic             ovf_evt;
  logic             unf_evt;

  // Next-count selection; events are only raised on a plain enabled step,
  // so clear and load implicitly suppress them.
  always_comb begin
    count_nxt = count;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    if (clear) begin
      count_nxt = RST_CNT;
    end else if (load) begin
      count_nxt = (load_value > limit) ? limit : load_value;
    end else if (enable) begin
      if (count > limit) begin
        // Limit was lowered under us: pull back into range quietly.
        count_nxt = limit;
      end else if (up_down) begin
        if (count == limit) begin
          ovf_evt   = 1'b1;
          count_nxt = (mode == WRAP) ? '0 : count;
        end else begin
          count_nxt = count + ONE;
        end
      end else begin
        if (count == '0) begin
          unf_evt   = 1'b1;
          count_nxt = (mode == WRAP) ? limit : count;
        end else begin
          count_nxt = count - ONE;
        end
      end
    end
  end

  // Count register and the registered one-cycle event pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= RST_CNT;
      wrap_pulse <= 1'b0;
    end else begin
      count      <= count_nxt;
      wrap_pulse <= ovf_evt | unf_evt;
    end
  end

  // Range flags follow count and limit with no register stage.
  always_comb begin
    at_max = (count == limit);
    at_min = (count == '0);
  end

  sticky_flag u_ovf_flag (
    .clk   (clk),
    .reset (reset),
    .set   (ovf_evt),
    .clr   (sticky_clr),
    .q     (ovf_sticky)
  );

  sticky_flag u_unf_flag (
    .clk   (clk),
    .reset (reset),
    .set   (unf_evt),
    .clr   (sticky_clr),
    .q     (unf_sticky)
  );

endmodule : param_updown_counter

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter (WIDTH=4, RESET_VAL=2).
module tb_param_updown_counter;
  import updown_pkg::*;

  localparam int W  = 4;
  localparam int RV = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          enable;
  logic          up_down;
  counter_mode_e mode;
  logic [W-1:0]  limit;
  logic          load;
  logic [W-1:0]  load_value;
  logic          sticky_clr;
  logic [W-1:0]  count;
  logic          at_max;
  logic          at_min;
  logic          wrap_pulse;
  logic          ovf_sticky;
  logic          unf_sticky;

  param_updown_counter #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .enable     (enable),
    .up_down    (up_down),
    .mode       (mode),
    .limit      (limit),
    .load       (load),
    .load_value (load_value),
    .sticky_clr (sticky_clr),
    .count      (count),
    .at_max     (at_max),
    .at_min     (at_min),
    .wrap_pulse (wrap_pulse),
    .ovf_sticky (ovf_sticky),
    .unf_sticky (unf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic mx, mn, wp, ov, un;
  } obs_t;

  typedef struct packed {
    logic          clr, ld, en, up;
    counter_mode_e md;
    logic [W-1:0]  lim, lv;
    logic          sclr;
    obs_t          exp;
  } vec_t;

  vec_t vecs[$];
  obs_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic clr, input logic ld, input logic en, input logic up,
                              input counter_mode_e md, input int lim, input int lv, input logic sclr,
                              input int cnt, input logic mx, input logic mn, input logic wp,
                              input logic ov, input logic un);
    vec_t v;
    v.clr = clr; v.ld = ld; v.en = en; v.up = up; v.md = md;
    v.lim = W'(lim); v.lv = W'(lv); v.sclr = sclr;
    v.exp.cnt = W'(cnt); v.exp.mx = mx; v.exp.mn = mn;
    v.exp.wp = wp; v.exp.ov = ov; v.exp.un = un;
    return v;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.cnt = count; o.mx = at_max; o.mn = at_min;
    o.wp = wrap_pulse; o.ov = ovf_sticky; o.un = unf_sticky;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got cnt=%0d max=%b min=%b wp=%b ovf=%b unf=%b, want cnt=%0d max=%b min=%b wp=%b ovf=%b unf=%b",
               name, got.cnt, got.mx, got.mn, got.wp, got.ov, got.un,
               exp.cnt, exp.mx, exp.mn, exp.wp, exp.ov, exp.un);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, got, exp);
    end
  endtask

  // Drive one vector at the falling edge, queue its expectation, compare after the rising edge.
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    clear = v.clr; load = v.ld; enable = v.en; up_down = v.up; mode = v.md;
    limit = v.lim; load_value = v.lv; sticky_clr = v.sclr;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL vec%0d: scoreboard empty, got cnt=%0d, want an entry", idx, count);
    end else begin
      check($sformatf("vec%0d", idx), sample(), sb_q.pop_front());
    end
  endtask

  function automatic obs_t mk_obs(input int cnt, input logic mx, input logic mn,
                                  input logic wp, input logic ov, input logic un);
    obs_t o;
    o.cnt = W'(cnt); o.mx = mx; o.mn = mn; o.wp = wp; o.ov = ov; o.un = un;
    return o;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //              clr ld en up mode      lim lv sclr  cnt mx mn wp ov un
    vecs.push_back(mk(0, 1, 0, 0, WRAP,      9, 0, 0,    0, 0, 1, 0, 0, 0));
    // 12 up-steps from 0 in WRAP with limit 9: 1..9,0,1,2
    for (int i = 1; i <= 12; i++) begin
      vecs.push_back(mk(0, 0, 1, 1, WRAP, 9, 0, 0, i % 10, (i % 10) == 9, (i % 10) == 0,
                        i == 10, i >= 10, 1'b0));
    end
    vecs.push_back(mk(0, 0, 0, 0, WRAP,      9, 0, 1,    2, 0, 0, 0, 0, 0));
    // Saturating underflow, three times
    vecs.push_back(mk(0, 1, 0, 0, SATURATE,  9, 0, 0,    0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 1, 0, SATURATE, 9, 0, 0,  0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, SATURATE,  9, 0, 0,    0, 0, 1, 0, 0, 1));
    // Load clamps to limit; load beats enable; plain decrement
    vecs.push_back(mk(0, 1, 0, 0, WRAP,      9, 15, 0,   9, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, WRAP,      9, 4, 0,    4, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, WRAP,      9, 0, 0,    3, 0, 0, 0, 0, 1));
    // Limit lowered below count: pulled back with no event
    vecs.push_back(mk(0, 1, 0, 0, WRAP,      9, 8, 0,    8, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, WRAP,      5, 0, 0,    5, 1, 0, 0, 0, 1));
    // Overflow coincident with sticky_clr: ovf set wins, unf cleared
    vecs.push_back(mk(0, 0, 1, 1, WRAP,      5, 0, 1,    0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, WRAP,      5, 0, 1,    0, 0, 1, 0, 0, 0));
    // limit == 0: every step is an event, count stays 0
    vecs.push_back(mk(0, 0, 1, 1, WRAP,      0, 0, 0,    0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, SATURATE,  0, 0, 0,    0, 1, 1, 1, 1, 1));
    // Clear and load suppress events at the limit
    vecs.push_back(mk(0, 1, 0, 0, WRAP,      9, 9, 1,    9, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, WRAP,      9, 0, 0,    RV, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, WRAP,      9, 9, 0,    9, 1, 0, 0, 0, 0));
    // Saturating overflow holds; wrapping underflow goes to limit
    vecs.push_back(mk(0, 0, 1, 1, SATURATE,  9, 0, 0,    9, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, WRAP,      9, 0, 1,    0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, WRAP,      9, 0, 0,    9, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, WRAP,      9, 7, 0,    7, 0, 0, 0, 0, 1));

    reset = 1'b1; clear = 1'b0; enable = 1'b0; up_down = 1'b0; mode = WRAP;
    limit = W'(9); load = 1'b0; load_value = '0; sticky_clr = 1'b0;
    #12;
    check("reset_state", sample(), mk_obs(RV, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // at_max follows limit without a clock edge (count is 7 here)
    #2;
    limit = W'(7);
    #1;
    check_bit("at_max_comb_hi", at_max, 1'b1);
    limit = W'(9);
    #1;
    check_bit("at_max_comb_lo", at_max, 1'b0);

    // Reset mid-count at 7 while counting up
    @(negedge clk);
    clear = 1'b0; load = 1'b0; sticky_clr = 1'b0; mode = WRAP;
    enable = 1'b1; up_down = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", sample(), mk_obs(RV, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("reset_held", sample(), mk_obs(RV, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("resume_1", sample(), mk_obs(RV + 1, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("resume_2", sample(), mk_obs(RV + 2, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_param_updown_counter

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter RESET_VAL, default 0: value of count after reset and after clear.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port clear, input, 1 bit: synchronous return of count to RESET_VAL.
REQ-006 SHALL have port enable, input, 1 bit: count one step this cycle.
REQ-007 SHALL have port up_down, input, 1 bit: 1 = increment, 0 = decrement.
REQ-008 SHALL have port mode, input, counter_mode_e: WRAP or SATURATE.
REQ-009 SHALL have port limit, input, WIDTH bits: upper bound of the count range, so the range is 0..limit.
REQ-010 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-011 SHALL have port load_value, input, WIDTH bits: value taken on load.
REQ-012 SHALL have port sticky_clr, input, 1 bit: clears ovf_sticky and unf_sticky.
REQ-013 SHALL have port count, output, WIDTH bits: current count.
REQ-014 SHALL have port at_max, output, 1 bit: count == limit.
REQ-015 SHALL have port at_min, output, 1 bit: count == 0.
REQ-016 SHALL have port wrap_pulse, output, 1 bit: one-cycle pulse for a wrap or saturation event.
REQ-017 SHALL have port ovf_sticky, output, 1 bit: an up-step at limit has occurred.
REQ-018 SHALL have port unf_sticky, output, 1 bit: a down-step at 0 has occurred.

Function
REQ-019 SHALL update count with this per-cycle priority: clear > load > enable > hold.
REQ-020 SHALL, on load, set count to min(load_value, limit).
REQ-021 SHALL, on an enabled up-step with count < limit, set count to count+1; on an enabled down-step with count > 0, set count to count-1.
REQ-022 SHALL, on an enabled up-step at count == limit, set count to 0 in WRAP mode and hold count in SATURATE mode; this is an overflow event.
REQ-023 SHALL, on an enabled down-step at count == 0, set count to limit in WRAP mode and hold count in SATURATE mode; this is an underflow event.
REQ-024 SHALL, on an enabled step while count > limit (limit lowered at runtime), set count to limit with no event.
REQ-025 SHALL register wrap_pulse so it is high for exactly the cycle following an overflow or underflow event, in either mode.
REQ-026 SHALL set ovf_sticky on an overflow event and unf_sticky on an underflow event; the flags hold until sticky_clr or reset.
REQ-027 SHALL, when sticky_clr and a new event coincide in the same cycle, leave the corresponding flag set (set wins).
REQ-028 SHALL derive at_max and at_min combinationally from count and limit, with no added latency.
REQ-029 SHALL treat limit == 0 as legal: up-steps are overflow events and down-steps are underflow events, and count remains 0.
REQ-030 SHALL suppress all events when clear or load is active in the same cycle.

Reset
REQ-031 SHALL, while reset is high, immediately force count = RESET_VAL and wrap_pulse = 0, ovf_sticky = 0, unf_sticky = 0, independent of clk.
REQ-032 SHALL resume counting on the first rising clk edge after reset deasserts, whether or not a count was in progress when reset asserted.

Structure
REQ-033 SHALL define typedef counter_mode_e {WRAP, SATURATE} in the shared package updown_pkg.
REQ-034 SHALL implement each sticky flag as an instance of the sub-module sticky_flag, with inputs set and clr, output q, and set-wins priority.

Verification
REQ-035 SHALL cover: WIDTH=4, limit=9, WRAP, 12 up-steps from 0 -> count 0..9,0,1,2; wrap_pulse once, in the cycle after 9->0; ovf_sticky=1.
REQ-036 SHALL cover: SATURATE, limit=9, count=0, 3 down-steps -> count stays 0; wrap_pulse for 3 cycles; unf_sticky=1; at_min=1.
REQ-037 SHALL cover: load with load_value=15, limit=9 -> count=9, at_max=1; load and enable in the same cycle -> count = loaded value.
REQ-038 SHALL cover: count=8, limit lowered to 5, one enabled up-step -> count=5; no wrap_pulse.
REQ-039 SHALL cover: sticky_clr coincident with an overflow -> ovf_sticky stays 1; sticky_clr alone on the next cycle -> 0.
REQ-040 SHALL cover: reset asserted mid-count at count=7 -> count=RESET_VAL immediately, without a clock edge; counting resumes at the first edge after release.
